// File: rtl/bit_xor_pkg.sv
// Shared opcodes and Fenwick index masks for the 8-element 1-bit XOR tree.
package bit_xor_pkg;

  localparam logic [1:0] OP_UPDATE = 2'b00;
  localparam logic [1:0] OP_QUERY  = 2'b01;

  // Nodes touched by a point update of element p: j=p+1, j+=lowbit(j), j<=8.
  function automatic logic [7:0] upd_mask(input logic [2:0] idx);
    logic [7:0] m;
    case (idx)
      3'd0:    m = 8'h8B;
      3'd1:    m = 8'h8A;
      3'd2:    m = 8'h8C;
      3'd3:    m = 8'h88;
      3'd4:    m = 8'hB0;
      3'd5:    m = 8'hA0;
      3'd6:    m = 8'hC0;
      default: m = 8'h80;
    endcase
    return m;
  endfunction

  // Nodes read by a prefix query of length q: j=q, j-=lowbit(j), j>0.
  function automatic logic [7:0] qry_mask(input logic [2:0] idx);
    logic [7:0] m;
    case (idx)
      3'd0:    m = 8'h00;
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h02;
      3'd3:    m = 8'h06;
      3'd4:    m = 8'h08;
      3'd5:    m = 8'h18;
      3'd6:    m = 8'h28;
      default: m = 8'h68;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bit_xor_node.sv
// One Fenwick tree node: a single toggle flop with asynchronous clear.
module bit_xor_node (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= q ^ t;
  end

endmodule

// File: rtl/bit_xor_fenwick8.sv
// 8-element 1-bit XOR Fenwick tree: registered point update, combinational prefix query.
module bit_xor_fenwick8
  import bit_xor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inst,
  input  logic [2:0] idx,
  input  logic       xorval,
  output logic       rangexor
);

  logic       upd_en;
  logic       qry_en;
  logic [7:0] toggle;
  logic [7:0] node;
  logic [7:0] sel;

  // Decoding from one opcode keeps update and query mutually exclusive.
  assign upd_en = (inst == OP_UPDATE);
  assign qry_en = (inst == OP_QUERY);
  assign toggle = {8{xorval & upd_en}} & upd_mask(idx);

  for (genvar k = 0; k < 8; k++) begin : g_node
    bit_xor_node u_node (
      .clk   (clk),
      .reset (reset),
      .t     (toggle[k]),
      .q     (node[k])
    );
  end

  // node[7] never appears in any query mask; the full 8-element prefix is not queryable.
  assign sel      = qry_en ? qry_mask(idx) : 8'h00;
  assign rangexor = ^(node & sel);

endmodule

// File: tb/tb_bit_xor_fenwick8.sv
// Self-checking bench for bit_xor_fenwick8 against a plain array-of-elements model.
module tb_bit_xor_fenwick8;

  logic       clk;
  logic       reset;
  logic [1:0] inst;
  logic [2:0] idx;
  logic       xorval;
  logic       rangexor;

  int errors = 0;
  int checks = 0;

  // Reference model: the raw element array, not tree nodes.
  logic a [8];

  bit_xor_fenwick8 dut (
    .clk      (clk),
    .reset    (reset),
    .inst     (inst),
    .idx      (idx),
    .xorval   (xorval),
    .rangexor (rangexor)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_prefix(input int q);
    logic r;
    r = 1'b0;
    for (int i = 0; i < q; i++) r ^= a[i];
    return r;
  endfunction

  function automatic logic model_out(input logic [1:0] op, input logic [2:0] i);
    return (op == 2'b01) ? model_prefix(int'(i)) : 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) a[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Apply inputs after a falling edge and settle to the sample point.
  task automatic drive(input logic [1:0] op, input logic [2:0] i, input logic v);
    @(negedge clk);
    inst   = op;
    idx    = i;
    xorval = v;
    #2;
  endtask

  // Cross the rising edge; the model absorbs whatever the DUT committed.
  task automatic step();
    @(posedge clk);
    if (!reset && inst == 2'b00) a[idx] ^= xorval;
    #1;
  endtask

  task automatic update(input logic [2:0] p, input logic v);
    drive(2'b00, p, v);
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b1;
    inst   = 2'b01;
    idx    = 3'd0;
    xorval = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int q = 0; q < 8; q++) begin
      drive(2'b01, 3'(q), 1'b0);
      checks++;
      if (rangexor !== 1'b0) begin
        errors++;
        $display("FAIL reset_query q=%0d got=%b exp=0", q, rangexor);
      end
    end
  endtask

  task automatic test_single_update();
    int  qs  [4] = '{1, 0, 7, 4};
    logic ex [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    update(3'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 3'(qs[k]), 1'b0);
      checks++;
      if (rangexor !== ex[k]) begin
        errors++;
        $display("FAIL single_update q=%0d got=%b exp=%b", qs[k], rangexor, ex[k]);
      end
    end
  endtask

  task automatic test_multi_update();
    update(3'd6, 1'b1);
    drive(2'b01, 3'd7, 1'b0);
    checks++;
    if (rangexor !== 1'b0) begin
      errors++;
      $display("FAIL multi_p6 q=7 got=%b exp=0", rangexor);
    end
    drive(2'b01, 3'd6, 1'b0);
    checks++;
    if (rangexor !== 1'b1) begin
      errors++;
      $display("FAIL multi_p6 q=6 got=%b exp=1", rangexor);
    end
    update(3'd2, 1'b1);
    drive(2'b01, 3'd3, 1'b0);
    checks++;
    if (rangexor !== 1'b0) begin
      errors++;
      $display("FAIL multi_p2 q=3 got=%b exp=0", rangexor);
    end
    drive(2'b01, 3'd2, 1'b0);
    checks++;
    if (rangexor !== 1'b1) begin
      errors++;
      $display("FAIL multi_p2 q=2 got=%b exp=1", rangexor);
    end
  endtask

  task automatic test_nop();
    logic snap [8];
    for (int i = 0; i < 8; i++) snap[i] = a[i];
    update(3'd3, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive((k % 2 == 0) ? 2'b10 : 2'b11, 3'(k), 1'b1);
      checks++;
      if (rangexor !== 1'b0) begin
        errors++;
        $display("FAIL nop_output op=%b idx=%0d got=%b exp=0", inst, k, rangexor);
      end
      step();
    end
    for (int i = 0; i < 8; i++) a[i] = snap[i];
    for (int q = 0; q < 8; q++) begin
      drive(2'b01, 3'(q), 1'b0);
      checks++;
      if (rangexor !== model_prefix(q)) begin
        errors++;
        $display("FAIL nop_state q=%0d got=%b exp=%b", q, rangexor, model_prefix(q));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [2:0] i;
    logic       v;
    logic       e;
    for (int n = 0; n < 1200; n++) begin
      // Bias toward updates/queries, with occasional reserved opcodes.
      case ($urandom_range(0, 9))
        0:          op = 2'b10;
        1:          op = 2'b11;
        2, 3, 4, 5: op = 2'b00;
        default:    op = 2'b01;
      endcase
      i = 3'($urandom_range(0, 7));
      v = 1'($urandom_range(0, 1));
      drive(op, i, v);
      e = model_out(op, i);
      checks++;
      if (rangexor !== e) begin
        errors++;
        $display("FAIL random n=%0d op=%b idx=%0d got=%b exp=%b", n, op, i, rangexor, e);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    // Update then immediately query: the new value must be visible next cycle.
    for (int p = 0; p < 8; p++) begin
      update(3'(p), 1'b1);
      drive(2'b01, 3'd7, 1'b0);
      e = model_prefix(7);
      checks++;
      if (rangexor !== e) begin
        errors++;
        $display("FAIL back_to_back p=%0d got=%b exp=%b", p, rangexor, e);
      end
    end
  endtask

  task automatic test_async_reset();
    update(3'd1, 1'b1);
    update(3'd4, 1'b1);
    if (model_prefix(7) == 1'b0) update(3'd0, 1'b1);
    drive(2'b01, 3'd7, 1'b0);
    checks++;
    if (rangexor !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset q=7 got=%b exp=1", rangexor);
    end
    // Pulse reset between edges; clearing must not wait for a clock.
    reset = 1'b1;
    #1;
    checks++;
    if (rangexor !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_during q=7 got=%b exp=0", rangexor);
    end
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rangexor !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after q=7 got=%b exp=0", rangexor);
    end
    step();
    for (int q = 0; q < 8; q++) begin
      drive(2'b01, 3'(q), 1'b0);
      checks++;
      if (rangexor !== 1'b0) begin
        errors++;
        $display("FAIL post_reset q=%0d got=%b exp=0", q, rangexor);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_update();
    test_multi_update();
    test_nop();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
